// File: rtl/chess_mem_port_arbiter_if.sv
// rtl/chess_mem_port_arbiter_if.sv - VGA, keyboard and dmem port B signal bundle for the arbiter
interface chess_mem_port_arbiter_if #(
    parameter int ADDR_W     = 12,
    parameter int DATA_W     = 32,
    parameter int FIFO_DEPTH = 4
);
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    logic              vga_req;
    logic [ADDR_W-1:0] vga_addr;
    logic [DATA_W-1:0] vga_data;
    logic              vga_data_valid;
    logic              vga_stale;
    logic              kb_valid;
    logic [ADDR_W-1:0] kb_addr;
    logic [DATA_W-1:0] kb_data;
    logic              kb_ready;
    logic [ADDR_W-1:0] mem_address;
    logic [DATA_W-1:0] mem_data;
    logic              mem_wren;
    logic [DATA_W-1:0] mem_q;
    logic [CNT_W-1:0]  fifo_count;

    modport slave (
        input  vga_req, vga_addr, kb_valid, kb_addr, kb_data, mem_q,
        output vga_data, vga_data_valid, vga_stale, kb_ready,
               mem_address, mem_data, mem_wren, fifo_count
    );

    modport master (
        output vga_req, vga_addr, kb_valid, kb_addr, kb_data, mem_q,
        input  vga_data, vga_data_valid, vga_stale, kb_ready,
               mem_address, mem_data, mem_wren, fifo_count
    );
endinterface

// File: rtl/chess_mem_port_arbiter.sv
// rtl/chess_mem_port_arbiter.sv - dmem port B arbiter: VGA reads first, buffered keyboard writes with anti-starvation
module chess_mem_port_arbiter #(
    parameter int ADDR_W     = 12,
    parameter int DATA_W     = 32,
    parameter int FIFO_DEPTH = 4,
    parameter int MAX_WAIT   = 8
) (
    input  logic                   clock,
    input  logic                   reset,
    chess_mem_port_arbiter_if.slave bus
);
    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam int WAIT_W = $clog2(MAX_WAIT + 1);

    logic [ADDR_W-1:0] fifo_addr_q [FIFO_DEPTH];
    logic [DATA_W-1:0] fifo_data_q [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic              rd_issued_q, rd_issued_d;
    logic              rd_preempt_q, rd_preempt_d;
    logic [DATA_W-1:0] hold_q, hold_d;

    logic fifo_nonempty;
    logic write_slot;
    logic read_slot;
    logic push;
    logic pop;

    // kb_ready is forced low while reset is held, since count_q alone would read as empty
    assign fifo_nonempty = (count_q != '0);
    assign bus.kb_ready  = !reset && (count_q < CNT_W'(FIFO_DEPTH));
    assign write_slot    = fifo_nonempty && (!bus.vga_req || (wait_q == WAIT_W'(MAX_WAIT)));
    assign read_slot     = bus.vga_req && !write_slot;
    assign push          = bus.kb_valid && bus.kb_ready;
    assign pop           = write_slot;

    assign bus.fifo_count = count_q;

    always_comb begin
        bus.mem_address = bus.vga_addr;
        bus.mem_data    = '0;
        bus.mem_wren    = 1'b0;
        if (write_slot) begin
            bus.mem_address = fifo_addr_q[rd_ptr_q];
            bus.mem_data    = fifo_data_q[rd_ptr_q];
            bus.mem_wren    = 1'b1;
        end
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        if (push && !pop) begin
            count_d = count_q + CNT_W'(1);
        end else if (!push && pop) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    // The wait counter measures how long the head entry has been denied a slot
    always_comb begin
        wait_d = wait_q;
        if (write_slot || !fifo_nonempty) begin
            wait_d = '0;
        end else if (wait_q != WAIT_W'(MAX_WAIT)) begin
            wait_d = wait_q + WAIT_W'(1);
        end
    end

    always_comb begin
        rd_issued_d  = read_slot;
        rd_preempt_d = bus.vga_req && write_slot;
        hold_d       = rd_issued_q ? bus.mem_q : hold_q;
    end

    assign bus.vga_data       = rd_issued_q ? bus.mem_q : hold_q;
    assign bus.vga_data_valid = rd_issued_q;
    assign bus.vga_stale      = rd_preempt_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            wait_q       <= '0;
            rd_issued_q  <= 1'b0;
            rd_preempt_q <= 1'b0;
            hold_q       <= '0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            wait_q       <= wait_d;
            rd_issued_q  <= rd_issued_d;
            rd_preempt_q <= rd_preempt_d;
            hold_q       <= hold_d;
        end
    end

    // Storage needs no reset: the pointers and count define which entries are live
    always_ff @(posedge clock) begin
        if (push) begin
            fifo_addr_q[wr_ptr_q] <= bus.kb_addr;
            fifo_data_q[wr_ptr_q] <= bus.kb_data;
        end
    end
endmodule

// File: tb/tb_chess_mem_port_arbiter.sv
// tb/tb_chess_mem_port_arbiter.sv - directed vector bench for chess_mem_port_arbiter
module tb_chess_mem_port_arbiter;
    logic clock;
    logic reset;

    chess_mem_port_arbiter_if #(.ADDR_W(12), .DATA_W(32), .FIFO_DEPTH(4)) bus ();

    chess_mem_port_arbiter #(.ADDR_W(12), .DATA_W(32), .FIFO_DEPTH(4), .MAX_WAIT(8)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // dmem port B model: unwritten word k reads as k + 0x100
    logic [31:0] mem     [4096];
    logic        written [4096];
    always @(posedge clock) begin
        if (bus.mem_wren) begin
            mem[bus.mem_address]     <= bus.mem_data;
            written[bus.mem_address] <= 1'b1;
        end
        bus.mem_q <= written[bus.mem_address] ? mem[bus.mem_address]
                                              : 32'(bus.mem_address) + 32'h100;
    end

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input logic vreq, input logic [11:0] vaddr,
                         input logic kv, input logic [11:0] ka, input logic [31:0] kd);
        bus.vga_req  = vreq;
        bus.vga_addr = vaddr;
        bus.kb_valid = kv;
        bus.kb_addr  = ka;
        bus.kb_data  = kd;
    endtask

    typedef struct {
        logic        vreq;
        logic [11:0] vaddr;
        logic        kv;
        logic [11:0] ka;
        logic [31:0] kd;
        logic        wren;
        logic [11:0] maddr;
        logic [31:0] mdata;
        logic [2:0]  cnt;
        logic        rdy;
        logic        vv;
        logic        st;
        logic [31:0] vd;
    } vec_t;

    vec_t vecs [9];

    initial begin
        int widx;
        int idx;
        int last_c;
        int max_cnt;
        logic chk_after_full;
        logic acc;
        logic [31:0] fresh;

        for (int k = 0; k < 4096; k++) written[k] = 1'b0;

        //            vreq vaddr  kv  ka     kd        wren maddr  mdata     cnt rdy vv st vd
        vecs[0] = '{1'b0, 12'd5,  1'b1, 12'd36, 32'h49, 1'b0, 12'd5,  32'h0,  3'd0, 1'b1, 1'b0, 1'b0, 32'h0};
        vecs[1] = '{1'b0, 12'd5,  1'b0, 12'd0,  32'h0,  1'b1, 12'd36, 32'h49, 3'd1, 1'b1, 1'b0, 1'b0, 32'h0};
        vecs[2] = '{1'b1, 12'd36, 1'b0, 12'd0,  32'h0,  1'b0, 12'd36, 32'h0,  3'd0, 1'b1, 1'b0, 1'b0, 32'h0};
        vecs[3] = '{1'b0, 12'd7,  1'b0, 12'd0,  32'h0,  1'b0, 12'd7,  32'h0,  3'd0, 1'b1, 1'b1, 1'b0, 32'h49};
        vecs[4] = '{1'b0, 12'd7,  1'b1, 12'd10, 32'hAA, 1'b0, 12'd7,  32'h0,  3'd0, 1'b1, 1'b0, 1'b0, 32'h49};
        vecs[5] = '{1'b0, 12'd7,  1'b1, 12'd11, 32'hBB, 1'b1, 12'd10, 32'hAA, 3'd1, 1'b1, 1'b0, 1'b0, 32'h49};
        vecs[6] = '{1'b1, 12'd10, 1'b0, 12'd0,  32'h0,  1'b0, 12'd10, 32'h0,  3'd1, 1'b1, 1'b0, 1'b0, 32'h49};
        vecs[7] = '{1'b0, 12'd3,  1'b0, 12'd0,  32'h0,  1'b1, 12'd11, 32'hBB, 3'd1, 1'b1, 1'b1, 1'b0, 32'hAA};
        vecs[8] = '{1'b0, 12'd3,  1'b0, 12'd0,  32'h0,  1'b0, 12'd3,  32'h0,  3'd0, 1'b1, 1'b0, 1'b0, 32'hAA};

        reset = 1'b1;
        drive(1'b0, 12'd0, 1'b0, 12'd0, 32'h0);
        @(posedge clock);
        @(negedge clock);
        chk("rst_ready", 64'(bus.kb_ready), 64'd0);
        chk("rst_count", 64'(bus.fifo_count), 64'd0);
        chk("rst_wren", 64'(bus.mem_wren), 64'd0);
        chk("rst_vdata", 64'(bus.vga_data), 64'd0);
        chk("rst_valid", 64'(bus.vga_data_valid), 64'd0);
        chk("rst_stale", 64'(bus.vga_stale), 64'd0);
        tick();
        reset = 1'b0;

        // single write, read-after-write, push/pop overlap at count 1
        for (int i = 0; i < 9; i++) begin
            drive(vecs[i].vreq, vecs[i].vaddr, vecs[i].kv, vecs[i].ka, vecs[i].kd);
            @(negedge clock);
            chk($sformatf("v%0d_wren", i), 64'(bus.mem_wren), 64'(vecs[i].wren));
            chk($sformatf("v%0d_maddr", i), 64'(bus.mem_address), 64'(vecs[i].maddr));
            chk($sformatf("v%0d_mdata", i), 64'(bus.mem_data), 64'(vecs[i].mdata));
            chk($sformatf("v%0d_count", i), 64'(bus.fifo_count), 64'(vecs[i].cnt));
            chk($sformatf("v%0d_ready", i), 64'(bus.kb_ready), 64'(vecs[i].rdy));
            chk($sformatf("v%0d_valid", i), 64'(bus.vga_data_valid), 64'(vecs[i].vv));
            chk($sformatf("v%0d_stale", i), 64'(bus.vga_stale), 64'(vecs[i].st));
            chk($sformatf("v%0d_vdata", i), 64'(bus.vga_data), 64'(vecs[i].vd));
            tick();
        end

        // continuous VGA stream
        for (int j = 0; j < 12; j++) begin
            drive(1'b1, 12'(100 + j), 1'b0, 12'd0, 32'h0);
            @(negedge clock);
            if (j == 0) begin
                chk("stream_first_valid", 64'(bus.vga_data_valid), 64'd0);
            end else begin
                chk("stream_valid", 64'(bus.vga_data_valid), 64'd1);
                chk("stream_data", 64'(bus.vga_data), 64'(32'(100 + j - 1) + 32'h100));
            end
            tick();
        end

        // forced write slot after MAX_WAIT denied cycles
        drive(1'b1, 12'd300, 1'b1, 12'd200, 32'h1234);
        @(negedge clock);
        chk("force_push_ready", 64'(bus.kb_ready), 64'd1);
        tick();
        fresh = 32'h0;
        for (int j = 0; j < 11; j++) begin
            drive(1'b1, 12'(301 + j), 1'b0, 12'd0, 32'h0);
            @(negedge clock);
            chk($sformatf("force_wren_j%0d", j), 64'(bus.mem_wren), 64'(j == 8));
            if (j == 8) begin
                chk("force_addr", 64'(bus.mem_address), 64'd200);
                chk("force_data", 64'(bus.mem_data), 64'h1234);
                chk("force_pre_valid", 64'(bus.vga_data_valid), 64'd1);
                chk("force_pre_data", 64'(bus.vga_data), 64'(32'd308 + 32'h100));
                fresh = bus.vga_data;
            end
            if (j == 9) begin
                chk("force_stale", 64'(bus.vga_stale), 64'd1);
                chk("force_stale_valid", 64'(bus.vga_data_valid), 64'd0);
                chk("force_stale_data", 64'(bus.vga_data), 64'(32'd308 + 32'h100));
                chk("force_count", 64'(bus.fifo_count), 64'd0);
            end
            if (j == 10) begin
                chk("force_resume_valid", 64'(bus.vga_data_valid), 64'd1);
                chk("force_resume_data", 64'(bus.vga_data), 64'(32'd310 + 32'h100));
                chk("force_resume_stale", 64'(bus.vga_stale), 64'd0);
            end
            tick();
        end

        // five pushes against a full FIFO, drained one per wait window
        widx = 0;
        idx = 0;
        last_c = 0;
        max_cnt = 0;
        chk_after_full = 1'b0;
        for (int c = 0; c < 60; c++) begin
            drive(1'b1, 12'(500 + c), idx < 5, 12'(400 + idx), 32'hD00 + 32'(idx));
            @(negedge clock);
            if (int'(bus.fifo_count) > max_cnt) max_cnt = int'(bus.fifo_count);
            if (chk_after_full) begin
                chk("full_pop_count", 64'(bus.fifo_count), 64'd3);
                chk_after_full = 1'b0;
            end
            acc = bus.kb_valid && bus.kb_ready;
            if (bus.mem_wren) begin
                chk($sformatf("drain%0d_addr", widx), 64'(bus.mem_address), 64'(400 + widx));
                chk($sformatf("drain%0d_data", widx), 64'(bus.mem_data), 64'(32'hD00 + 32'(widx)));
                if (widx == 0) begin
                    chk("full_first_cycle", 64'(c), 64'd9);
                    chk("full_pop_count_before", 64'(bus.fifo_count), 64'd4);
                    chk("full_pop_ready", 64'(bus.kb_ready), 64'd0);
                    chk("full_pop_kvalid", 64'(bus.kb_valid), 64'd1);
                    chk_after_full = 1'b1;
                end else begin
                    chk($sformatf("drain%0d_gap", widx), 64'(c - last_c), 64'd9);
                end
                last_c = c;
                widx++;
            end
            tick();
            if (acc) idx++;
        end
        chk("drain_writes", 64'(widx), 64'd5);
        chk("drain_accepts", 64'(idx), 64'd5);
        chk("drain_max_count", 64'(max_cnt), 64'd4);

        // push and pop together at count 2
        drive(1'b1, 12'd50, 1'b1, 12'd600, 32'h600);
        tick();
        drive(1'b1, 12'd51, 1'b1, 12'd601, 32'h601);
        tick();
        drive(1'b0, 12'd52, 1'b1, 12'd602, 32'h602);
        @(negedge clock);
        chk("pp2_count", 64'(bus.fifo_count), 64'd2);
        chk("pp2_ready", 64'(bus.kb_ready), 64'd1);
        chk("pp2_wren", 64'(bus.mem_wren), 64'd1);
        chk("pp2_addr", 64'(bus.mem_address), 64'd600);
        tick();
        drive(1'b0, 12'd52, 1'b0, 12'd0, 32'h0);
        @(negedge clock);
        chk("pp2_after_count", 64'(bus.fifo_count), 64'd2);
        chk("pp2_after_addr", 64'(bus.mem_address), 64'd601);
        tick();
        @(negedge clock);
        chk("pp2_tail_addr", 64'(bus.mem_address), 64'd602);
        chk("pp2_tail_count", 64'(bus.fifo_count), 64'd1);
        tick();
        @(negedge clock);
        chk("pp2_empty", 64'(bus.fifo_count), 64'd0);
        tick();

        // asynchronous reset in the middle of a write slot
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 12'd60, 1'b1, 12'(700 + i), 32'h700 + 32'(i));
            tick();
        end
        drive(1'b0, 12'd61, 1'b0, 12'd0, 32'h0);
        @(negedge clock);
        chk("rstmid_wren_before", 64'(bus.mem_wren), 64'd1);
        chk("rstmid_addr_before", 64'(bus.mem_address), 64'd700);
        chk("rstmid_count_before", 64'(bus.fifo_count), 64'd3);
        #1;
        reset = 1'b1;
        #1;
        chk("rstmid_wren_now", 64'(bus.mem_wren), 64'd0);
        chk("rstmid_ready_now", 64'(bus.kb_ready), 64'd0);
        tick();
        tick();
        reset = 1'b0;
        @(negedge clock);
        chk("rstmid_count_after", 64'(bus.fifo_count), 64'd0);
        chk("rstmid_vdata_after", 64'(bus.vga_data), 64'd0);
        chk("rstmid_ready_after", 64'(bus.kb_ready), 64'd1);
        for (int j = 0; j < 15; j++) begin
            @(negedge clock);
            chk("rstmid_no_write", 64'(bus.mem_wren), 64'd0);
            tick();
        end
        chk("rstmid_mem700_untouched", 64'(written[700]), 64'd0);
        chk("rstmid_mem701_untouched", 64'(written[701]), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
